// File: rtl/xm23_fetch_stage.sv
// xm23_fetch_stage: XM23 instruction fetch stage.
// Holds the PC and fetches 16-bit words over a req/ack memory port. It hands
// registered inst/inst_valid/inst_pc to decode and honours the pipeline stall
// and branch redirects from later stages.
// Optional feature macro: XM23_FETCH_BKPT_EN adds an address breakpoint that
// halts fetch before the matching address is requested.
module xm23_fetch_stage #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc
`ifdef XM23_FETCH_BKPT_EN
  ,
  input  logic              bkpt_en,
  input  logic [ADDR_W-1:0] bkpt_addr,
  output logic              bkpt_hit
`endif
);

`ifdef XM23_FETCH_BKPT_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3
  } state_t;
`endif

  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ALIGN_MK = ~(ADDR_W'(1));

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] drain_pc;     // address of the request being drained
  logic [15:0]       skid_data;
  logic [ADDR_W-1:0] skid_pc;
  logic              skid_full;
  logic [ADDR_W-1:0] redir_pc;
  logic              stop_here;    // breakpoint matches before any request at PC
  logic              fetching;     // REQ state with a live request on the port

  assign redir_pc = redirect_pc & ALIGN_MK;

`ifdef XM23_FETCH_BKPT_EN
  logic issued;                    // a request at the current PC is already out
  assign stop_here = (state == S_REQ) && !issued && bkpt_en && (pc == bkpt_addr);
`else
  assign stop_here = 1'b0;
`endif

  assign fetching  = (state == S_REQ) && !stop_here;
  assign imem_req  = fetching || (state == S_DRAIN);
  assign imem_addr = (state == S_DRAIN) ? drain_pc : pc;

  // Fetch FSM, PC, skid buffer and registered outputs to decode.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC & ALIGN_MK;
      drain_pc   <= {ADDR_W{1'b0}};
      skid_data  <= 16'h0000;
      skid_pc    <= {ADDR_W{1'b0}};
      skid_full  <= 1'b0;
      inst       <= 16'h0000;
      inst_valid <= 1'b0;
      inst_pc    <= {ADDR_W{1'b0}};
`ifdef XM23_FETCH_BKPT_EN
      issued     <= 1'b0;
      bkpt_hit   <= 1'b0;
`endif
    end else if (redirect_valid) begin
      inst_valid <= 1'b0;
      skid_full  <= 1'b0;
      pc         <= redir_pc;
`ifdef XM23_FETCH_BKPT_EN
      issued     <= 1'b0;
      bkpt_hit   <= 1'b0;
`endif
      case (state)
        S_REQ: begin
          // An unanswered request must still be completed at its old address.
          if (fetching && !imem_ack) begin
            state    <= S_DRAIN;
            drain_pc <= pc;
          end else begin
            state <= S_REQ;
          end
        end
        S_DRAIN: state <= imem_ack ? S_REQ : S_DRAIN;
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          if (!stall) inst_valid <= 1'b0;
        end
        S_REQ: begin
          if (stop_here) begin
`ifdef XM23_FETCH_BKPT_EN
            state    <= S_HALT;
            bkpt_hit <= 1'b1;
`endif
            if (!stall) inst_valid <= 1'b0;
          end else if (imem_ack) begin
            if (!stall) begin
              inst       <= imem_rdata;
              inst_valid <= 1'b1;
              inst_pc    <= pc;
            end else begin
              skid_data <= imem_rdata;
              skid_pc   <= pc;
              skid_full <= 1'b1;
              state     <= S_HOLD;
            end
            pc <= pc + PC_STEP;
`ifdef XM23_FETCH_BKPT_EN
            issued <= 1'b0;
`endif
          end else begin
`ifdef XM23_FETCH_BKPT_EN
            issued <= 1'b1;
`endif
            if (!stall) inst_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            inst       <= skid_data;
            inst_pc    <= skid_pc;
            inst_valid <= skid_full;
            skid_full  <= 1'b0;
            state      <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (!stall) inst_valid <= 1'b0;
          if (imem_ack) state <= S_REQ;
        end
`ifdef XM23_FETCH_BKPT_EN
        S_HALT: begin
          if (!stall) inst_valid <= 1'b0;
          if (!bkpt_en) begin
            state    <= S_REQ;
            bkpt_hit <= 1'b0;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xm23_fetch_stage.sv
// tb_xm23_fetch_stage: directed bench for xm23_fetch_stage with a scoreboard.
// Stimulus pushes expected (pc, word) pairs; a monitor pops on each delivery.
// A memory responder acks requests under a per-test budget and delay.
module tb_xm23_fetch_stage;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] inst;
  logic        inst_valid;
  logic [15:0] inst_pc;
`ifdef XM23_FETCH_BKPT_EN
  logic        bkpt_en = 1'b0;
  logic [15:0] bkpt_addr = 16'h0000;
  logic        bkpt_hit;
`endif

  xm23_fetch_stage #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk_in(clk_in), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid), .inst_pc(inst_pc)
`ifdef XM23_FETCH_BKPT_EN
    , .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr), .bkpt_hit(bkpt_hit)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [15:0] pc; logic [15:0] data; } exp_t;
  exp_t sbq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int acks_left = 0;
  int ack_wait  = 0;
  int cnt = 0;
  bit pend = 1'b0;
  logic [15:0] paddr = 16'h0000;
  bit bkpt_phase = 1'b0;
  bit saw6 = 1'b0;
  int vcount;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h4008 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] pc);
    exp_t e;
    e.pc = pc;
    e.data = mem_word(pc);
    sbq.push_back(e);
  endtask

  task automatic wait_empty(input string name);
    int i;
    for (i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clk_in);
    if (sbq.size() != 0) chk({name, "_timeout"}, 32'(sbq.size()), 32'd0);
  endtask

  // Monitor: a new word is presented when valid is high after an unstalled edge.
  always @(posedge clk_in) begin
    #1;
    if (!reset && !stall && inst_valid) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_inst: got pc %h inst %h expected none", inst_pc, inst);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("inst_pc", {16'h0000, inst_pc}, {16'h0000, e.pc});
        chk("inst", {16'h0000, inst}, {16'h0000, e.data});
      end
    end
  end

  // Memory responder: acks after ack_wait idle cycles while budget remains.
  always @(posedge clk_in) begin
    #2;
    if (reset) begin
      imem_ack = 1'b0;
      pend = 1'b0;
    end else begin
      if (imem_ack) pend = 1'b0;
      if (imem_req) begin
        if (!pend) begin
          pend = 1'b1;
          paddr = imem_addr;
          cnt = 0;
        end else begin
          chk("addr_stable", {16'h0000, imem_addr}, {16'h0000, paddr});
        end
        if (bkpt_phase && imem_addr == 16'h0006) saw6 = 1'b1;
        if (acks_left > 0 && cnt >= ack_wait) begin
          imem_ack = 1'b1;
          imem_rdata = mem_word(imem_addr);
          acks_left--;
        end else begin
          imem_ack = 1'b0;
          if (acks_left > 0) cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        pend = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: reset state, then back-to-back fetch from 0.
    repeat (2) @(negedge clk_in);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", {16'h0000, inst}, 32'd0);
    chk("rst_pc", {16'h0000, inst_pc}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;
    acks_left = 5;
    for (int a = 0; a < 10; a += 2) push(16'(a));
    #1 chk("req_after_release", {31'd0, imem_req}, 32'd0);
    @(negedge clk_in);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", {16'h0000, imem_addr}, 32'd0);
    chk("valid_before", {31'd0, inst_valid}, 32'd0);
    @(negedge clk_in);
    chk("first_valid", {31'd0, inst_valid}, 32'd1);
    wait_empty("t1");
    repeat (2) @(negedge clk_in);
    chk("bubble", {31'd0, inst_valid}, 32'd0);

    // Test 2: stall for three cycles mid-stream.
    acks_left = 6;
    for (int a = 10; a < 22; a += 2) push(16'(a));
    repeat (2) @(negedge clk_in);
    stall = 1'b1;
    @(negedge clk_in);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    repeat (2) @(negedge clk_in);
    chk("stall_frozen_pc", {16'h0000, inst_pc}, 32'h000A);
    chk("stall_frozen_valid", {31'd0, inst_valid}, 32'd1);
    chk("stall_frozen_inst", {16'h0000, inst}, {16'h0000, mem_word(16'h000A)});
    stall = 1'b0;
    wait_empty("t2");
    repeat (2) @(negedge clk_in);

    // Test 3: each ack delayed by four cycles.
    ack_wait = 4;
    acks_left = 2;
    push(16'h0016);
    push(16'h0018);
    vcount = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      if (i == 2) chk("delay_addr", {16'h0000, imem_addr}, 32'h0016);
      if (inst_valid) vcount++;
    end
    chk("delay_valid_cycles", 32'(vcount), 32'd2);
    ack_wait = 0;
    wait_empty("t3");

    // Test 4: redirect to 0x0101 while a request is pending.
    @(negedge clk_in);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0101;
    @(negedge clk_in);
    redirect_valid = 1'b0;
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    chk("drain_addr", {16'h0000, imem_addr}, 32'h001A);
    chk("drain_valid", {31'd0, inst_valid}, 32'd0);
    acks_left = 3;
    push(16'h0100);
    push(16'h0102);
    repeat (2) @(negedge clk_in);
    chk("redir_addr", {16'h0000, imem_addr}, 32'h0100);
    wait_empty("t4");
    repeat (2) @(negedge clk_in);

    // Test 5: redirect coinciding with ack, then wrap at 0xFFFE.
    acks_left = 3;
    push(16'hFFFE);
    push(16'h0000);
    @(negedge clk_in);
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    @(negedge clk_in);
    redirect_valid = 1'b0;
    chk("wrap_start_addr", {16'h0000, imem_addr}, 32'hFFFE);
    @(negedge clk_in);
    chk("wrap_addr", {16'h0000, imem_addr}, 32'h0000);
    wait_empty("t5");
    repeat (2) @(negedge clk_in);

`ifdef XM23_FETCH_BKPT_EN
    // Test 6: breakpoint at 0x0006, then resume.
    acks_left = 0;
    reset = 1'b1;
    bkpt_en = 1'b1;
    bkpt_addr = 16'h0006;
    @(negedge clk_in);
    chk("bkpt_rst", {31'd0, bkpt_hit}, 32'd0);
    sbq.delete();
    reset = 1'b0;
    acks_left = 10;
    bkpt_phase = 1'b1;
    push(16'h0000);
    push(16'h0002);
    push(16'h0004);
    repeat (15) @(negedge clk_in);
    chk("bkpt_hit", {31'd0, bkpt_hit}, 32'd1);
    chk("bkpt_req", {31'd0, imem_req}, 32'd0);
    chk("bkpt_sb", 32'(sbq.size()), 32'd0);
    bkpt_phase = 1'b0;
    chk("bkpt_no6", {31'd0, saw6}, 32'd0);
    for (int a = 6; a < 20; a += 2) push(16'(a));
    bkpt_en = 1'b0;
    wait_empty("t6");
    chk("bkpt_clear", {31'd0, bkpt_hit}, 32'd0);
`endif

    repeat (4) @(negedge clk_in);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
